// File: rtl/stage_latch_pkg.sv
// Shared defines for the pipeline stage latches: stall encoding, stall vector
// stage indices, default payload geometry and the per-cycle action code.
package stage_latch_pkg;

    typedef enum logic {
        NO_STOP = 1'b0,
        STOP    = 1'b1
    } stall_e;

    // Bit positions of each pipeline stage inside the stall vector.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam int                      PAYLOAD_W_DEF   = 107;
    localparam logic [PAYLOAD_W_DEF-1:0] NOP_PAYLOAD_DEF = '0;

    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } action_e;

endpackage

// File: rtl/stage_latch_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, synchronous clear.
module sat_counter #(
    parameter int unsigned PERF_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clear,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {PERF_W{1'b1}})) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/stage_latch.sv
// Pipeline register between two stages with flush/bubble/advance/hold control,
// multi-cycle side-state pass-through and stall/bubble performance counters.
module stage_latch
    import stage_latch_pkg::*;
#(
    parameter int unsigned       DATA_W      = PAYLOAD_W_DEF,
    parameter int unsigned       STALL_W     = 6,
    parameter int unsigned       STAGE_IDX   = STALL_EX,
    parameter int unsigned       SIDE_W      = 64,
    parameter int unsigned       CNT_W       = 2,
    parameter int unsigned       PERF_W      = 16,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'(NOP_PAYLOAD_DEF)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STALL_W-1:0] stop_all,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic [SIDE_W-1:0]  side_input,
    input  logic [CNT_W-1:0]   count_input,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_payload,
    output logic [SIDE_W-1:0]  side_output,
    output logic [CNT_W-1:0]   count_output,
    output logic [PERF_W-1:0]  bubble_count,
    output logic [PERF_W-1:0]  stall_count
);

    localparam int unsigned DOWN_IDX = STAGE_IDX + 1;

    action_e action;
    logic    up_stop;
    logic    down_stop;
    // Only the two neighbouring stall bits matter; the rest are deliberately dropped.
    logic    unused_stall_bits;

    assign up_stop           = (stop_all[STAGE_IDX] == STOP);
    assign down_stop         = (stop_all[DOWN_IDX] == STOP);
    assign unused_stall_bits = ^stop_all;

    always_comb begin
        action = ACT_HOLD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (up_stop && !down_stop) begin
            action = ACT_BUBBLE;
        end else if (!up_stop) begin
            action = ACT_ADVANCE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_payload  <= NOP_PAYLOAD;
            side_output  <= '0;
            count_output <= '0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    out_valid    <= 1'b0;
                    out_payload  <= NOP_PAYLOAD;
                    side_output  <= '0;
                    count_output <= '0;
                end
                ACT_BUBBLE: begin
                    out_valid    <= 1'b0;
                    out_payload  <= NOP_PAYLOAD;
                    side_output  <= side_input;
                    count_output <= count_input;
                end
                ACT_ADVANCE: begin
                    out_valid    <= in_valid;
                    out_payload  <= in_payload;
                    side_output  <= side_input;
                    count_output <= '0;
                end
                default: begin
                    // Hold: payload frozen, execute-stage side state keeps circulating.
                    side_output  <= side_input;
                    count_output <= count_input;
                end
            endcase
        end
    end

    sat_counter #(.PERF_W(PERF_W)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (action == ACT_BUBBLE),
        .clear (1'b0),
        .count (bubble_count)
    );

    sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (action == ACT_HOLD),
        .clear (1'b0),
        .count (stall_count)
    );

endmodule

// File: tb/tb_stage_latch.sv
// Bench for stage_latch: vector table through a scoreboard queue, plus reset,
// recovery and counter saturation sequences on a narrow-counter instance.
module tb_stage_latch;

    localparam int OW = 1 + 107 + 64 + 2 + 16 + 16;

    logic         clock;
    logic         reset;
    logic [5:0]   stop_all;
    logic         flush;
    logic         in_valid;
    logic [106:0] in_payload;
    logic [63:0]  side_input;
    logic [1:0]   count_input;

    logic         m_vld, s_vld;
    logic [106:0] m_pay, s_pay;
    logic [63:0]  m_side, s_side;
    logic [1:0]   m_cnt, s_cnt;
    logic [15:0]  m_bub, m_stl;
    logic [3:0]   s_bub, s_stl;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    typedef struct {
        logic         flush;
        logic [5:0]   stop;
        logic         vld;
        logic [106:0] pay;
        logic [63:0]  side;
        logic [1:0]   cnt;
        logic         e_vld;
        logic [106:0] e_pay;
        logic [63:0]  e_side;
        logic [1:0]   e_cnt;
        logic [15:0]  e_bub;
        logic [15:0]  e_stl;
    } vec_t;

    vec_t vecs[12];

    stage_latch dut_m (
        .clock(clock), .reset(reset), .stop_all(stop_all), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .side_input(side_input),
        .count_input(count_input), .out_valid(m_vld), .out_payload(m_pay),
        .side_output(m_side), .count_output(m_cnt), .bubble_count(m_bub),
        .stall_count(m_stl)
    );

    stage_latch #(.PERF_W(4)) dut_s (
        .clock(clock), .reset(reset), .stop_all(stop_all), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .side_input(side_input),
        .count_input(count_input), .out_valid(s_vld), .out_payload(s_pay),
        .side_output(s_side), .count_output(s_cnt), .bubble_count(s_bub),
        .stall_count(s_stl)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(input logic f, input logic [5:0] st, input logic v,
                                input logic [106:0] p, input logic [63:0] sd,
                                input logic [1:0] c, input logic ev,
                                input logic [106:0] ep, input logic [63:0] esd,
                                input logic [1:0] ec, input logic [15:0] eb,
                                input logic [15:0] es);
        vec_t r;
        r.flush = f; r.stop = st; r.vld = v; r.pay = p; r.side = sd; r.cnt = c;
        r.e_vld = ev; r.e_pay = ep; r.e_side = esd; r.e_cnt = ec; r.e_bub = eb; r.e_stl = es;
        return r;
    endfunction

    function automatic logic [OW-1:0] pack(input logic v, input logic [106:0] p,
                                           input logic [63:0] sd, input logic [1:0] c,
                                           input logic [15:0] b, input logic [15:0] s);
        return {v, p, sd, c, b, s};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // driver
    task automatic drive(input logic f, input logic [5:0] st, input logic v,
                         input logic [106:0] p, input logic [63:0] sd, input logic [1:0] c);
        flush = f; stop_all = st; in_valid = v; in_payload = p;
        side_input = sd; count_input = c;
    endtask

    // scoreboard: pop one expectation after the edge and compare against dut_m
    task automatic step_and_check(input string name);
        logic [OW-1:0] exp;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got none expected entry", name);
        end else begin
            exp = exp_q.pop_front();
            check(name, pack(m_vld, m_pay, m_side, m_cnt, m_bub, m_stl), exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 6'b000000, 1, 107'h1234, 64'h11, 2'd3,
                      1, 107'h1234, 64'h11, 2'd0, 16'd0, 16'd0);
        vecs[1]  = mk(0, 6'b001000, 1, 107'h9999, 64'hAAAA_0000_5555, 2'd1,
                      0, 107'h0, 64'hAAAA_0000_5555, 2'd1, 16'd1, 16'd0);
        vecs[2]  = mk(0, 6'b000000, 1, 107'h77, 64'h22, 2'd2,
                      1, 107'h77, 64'h22, 2'd0, 16'd1, 16'd0);
        vecs[3]  = mk(0, 6'b011000, 0, 107'h55, 64'h33, 2'd1,
                      1, 107'h77, 64'h33, 2'd1, 16'd1, 16'd1);
        vecs[4]  = mk(0, 6'b011000, 1, 107'h56, 64'h44, 2'd2,
                      1, 107'h77, 64'h44, 2'd2, 16'd1, 16'd2);
        vecs[5]  = mk(0, 6'b011000, 1, 107'h57, 64'h45, 2'd3,
                      1, 107'h77, 64'h45, 2'd3, 16'd1, 16'd3);
        vecs[6]  = mk(1, 6'b001000, 1, 107'h58, 64'h66, 2'd3,
                      0, 107'h0, 64'h0, 2'd0, 16'd1, 16'd3);
        vecs[7]  = mk(1, 6'b011000, 1, 107'h59, 64'h67, 2'd2,
                      0, 107'h0, 64'h0, 2'd0, 16'd1, 16'd3);
        vecs[8]  = mk(0, 6'b110111, 1, 107'hABC, 64'h88, 2'd2,
                      1, 107'hABC, 64'h88, 2'd0, 16'd1, 16'd3);
        vecs[9]  = mk(0, 6'b101111, 1, 107'hBBB, 64'h99, 2'd2,
                      0, 107'h0, 64'h99, 2'd2, 16'd2, 16'd3);
        vecs[10] = mk(0, 6'b000000, 0, 107'hDEAD, 64'h0, 2'd1,
                      0, 107'hDEAD, 64'h0, 2'd0, 16'd2, 16'd3);
        vecs[11] = mk(0, 6'b111001, 1, 107'hBEEF, 64'h5, 2'd3,
                      0, 107'hDEAD, 64'h5, 2'd3, 16'd2, 16'd4);

        reset = 1'b0;
        drive(0, 6'b000000, 0, 107'h0, 64'h0, 2'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", pack(m_vld, m_pay, m_side, m_cnt, m_bub, m_stl), '0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].flush, vecs[i].stop, vecs[i].vld, vecs[i].pay,
                  vecs[i].side, vecs[i].cnt);
            exp_q.push_back(pack(vecs[i].e_vld, vecs[i].e_pay, vecs[i].e_side,
                                 vecs[i].e_cnt, vecs[i].e_bub, vecs[i].e_stl));
            step_and_check($sformatf("vec%0d", i));
        end

        // asynchronous reset while out_valid is high
        drive(0, 6'b000000, 1, 107'h5A, 64'h7, 2'd1);
        exp_q.push_back(pack(1, 107'h5A, 64'h7, 2'd0, 16'd2, 16'd4));
        step_and_check("pre_reset_advance");
        #3 reset = 1'b0;
        #1;
        check("async_reset_main", pack(m_vld, m_pay, m_side, m_cnt, m_bub, m_stl), '0);
        check("async_reset_narrow",
              pack(s_vld, s_pay, s_side, s_cnt, {12'd0, s_bub}, {12'd0, s_stl}), '0);
        #1 reset = 1'b1;
        drive(0, 6'b000000, 1, 107'h321, 64'hC0FFEE, 2'd2);
        exp_q.push_back(pack(1, 107'h321, 64'hC0FFEE, 2'd0, 16'd0, 16'd0));
        step_and_check("post_reset_advance");

        // 20 bubbles: narrow counter pins at 15, wide one keeps counting
        drive(0, 6'b001000, 1, 107'h42, 64'h20, 2'd1);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] exp_s;
            exp_s = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
            exp_q.push_back(pack(0, 107'h0, 64'h20, 2'd1, 16'(i + 1), 16'd0));
            step_and_check($sformatf("bubble_run%0d", i));
            check($sformatf("sat_bubble%0d", i), OW'({s_bub, s_stl}), OW'({exp_s[3:0], 4'd0}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_latch.md
STAGE_LATCH -- requirements
Module: stage_latch

Interface
REQ-001 Parameter DATA_W, default 107, SHALL set the width of the forwarded stage payload (write addr/enable/data, hi/lo/whilo, aluop, mem address, reg2 packed).
REQ-002 Parameter STALL_W, default 6, SHALL set the width of the stall vector.
REQ-003 Parameter STAGE_IDX, default 3, SHALL select the stall bit of the upstream stage; STAGE_IDX+1 is the downstream stage, and STAGE_IDX+1 < STALL_W SHALL hold.
REQ-004 Parameter SIDE_W, default 64, SHALL set the width of the multi-cycle side state (hilo temp).
REQ-005 Parameter CNT_W, default 2, SHALL set the width of the multi-cycle cycle counter.
REQ-006 Parameter PERF_W, default 16, SHALL set the width of the stall/bubble performance counters.
REQ-007 Parameter NOP_PAYLOAD, default all-zero DATA_W, SHALL be the payload loaded on reset, bubble and flush.
REQ-008 Ports SHALL be, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stop_all  in  STALL_W  per-stage stall vector, 1 = Stop.
- flush  in  1  discard stage contents.
- in_valid  in  1  upstream payload valid.
- in_payload  in  DATA_W  upstream payload.
- side_input  in  SIDE_W  multi-cycle temp from the execute stage.
- count_input  in  CNT_W  multi-cycle cycle count from the execute stage.
- out_valid  out  1  registered payload valid.
- out_payload  out  DATA_W  registered payload.
- side_output  out  SIDE_W  registered temp, fed back to the execute stage.
- count_output  out  CNT_W  registered cycle count, fed back to the execute stage.
- bubble_count  out  PERF_W  saturating count of inserted bubbles.
- stall_count  out  PERF_W  saturating count of hold cycles.

Function
REQ-009 Each cycle SHALL take exactly one action, in priority order: flush, bubble, advance, hold.
REQ-010 Flush (flush=1) SHALL load out_payload=NOP_PAYLOAD, out_valid=0, side_output=0, count_output=0.
REQ-011 Bubble (stop_all[STAGE_IDX]=1, stop_all[STAGE_IDX+1]=0) SHALL load out_payload=NOP_PAYLOAD, out_valid=0, side_output=side_input, count_output=count_input, and increment bubble_count.
REQ-012 Advance (stop_all[STAGE_IDX]=0) SHALL load out_payload=in_payload, out_valid=in_valid, side_output=side_input, count_output=0.
REQ-013 Hold (stop_all[STAGE_IDX]=1, stop_all[STAGE_IDX+1]=1) SHALL keep out_payload and out_valid unchanged, load side_output=side_input and count_output=count_input, and increment stall_count.
REQ-014 Latency SHALL be one cycle from input to output on advance; there is no combinational input-to-output path.
REQ-015 bubble_count and stall_count SHALL saturate at 2^PERF_W-1 and never wrap.
REQ-016 Flush together with any stall combination SHALL behave as flush only, with neither performance counter incrementing.
REQ-017 Stall bits other than STAGE_IDX and STAGE_IDX+1 SHALL be ignored.
REQ-018 count_output SHALL be truncated to CNT_W with no arithmetic in this block; count_input is passed through unmodified.

Reset
REQ-019 reset=0 SHALL asynchronously force out_payload=NOP_PAYLOAD, out_valid=0, side_output=0, count_output=0, bubble_count=0, stall_count=0, regardless of clock.
REQ-020 Reset asserted mid multi-cycle operation SHALL discard the side state; the first edge after deassertion SHALL follow REQ-009.

Structure
REQ-021 The stall encoding (Stop/NoStop), the stage index constants and the default NOP payload SHALL live in the shared defines package.
REQ-022 The two saturating counters SHALL be one sub-module, sat_counter (parameter PERF_W, inputs inc and clear), instantiated twice; everything else is flat.

Verification
REQ-023 Reset: reset=0 mid-cycle with out_valid=1 -> all outputs 0 immediately, before the next clock edge.
REQ-024 Advance: in_payload=0x1234, in_valid=1, stop_all=0 -> out_payload=0x1234 and out_valid=1 at the next edge; count_output=0.
REQ-025 Bubble: stop_all=6'b001000, side_input=0xAAAA_0000_5555, count_input=2'b01 -> out_valid=0, out_payload=NOP, side_output=0xAAAA_0000_5555, count_output=1, bubble_count=1.
REQ-026 Hold: stop_all=6'b011000 for 3 cycles after payload 0x77 -> out_payload stays 0x77, stall_count=3, count_output tracks count_input each cycle.
REQ-027 Flush priority: flush=1 with stop_all=6'b001000 -> out_valid=0, side_output=0, and both performance counters unchanged.
REQ-028 Saturation: with PERF_W=4, apply 20 bubble cycles -> bubble_count=15 and holds at 15.
